// File: rtl/ea_sequencer.sv
// rtl/ea_sequencer.sv - LC-3 effective-address sequencer: decode, offset add, optional LDI/STI pointer fetch.
// Optional pointer-fetch path is built only when EA_INDIRECT_EN is defined.
module ea_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] IR,
    input  logic [15:0] PC,
    output logic [2:0]  BaseR_Sel,
    input  logic [15:0] BaseR,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    input  logic        Mem_Rdy,
    input  logic [15:0] Mem_Data,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] EA,
    output logic        Illegal
);

`ifdef EA_INDIRECT_EN
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_CALC, S_IND, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_CALC, S_DONE} state_t;
`endif

    typedef enum logic [2:0] {M_PC9, M_PC11, M_BASE0, M_BASE6, M_NONE} mode_t;

    state_t      state, state_d;
    mode_t       mode_q, mode_d;
    logic        ind_q, ind_d;
    logic [15:0] ir_q, pc_q;
    logic [15:0] sum_d;
    logic        illegal_d;
    logic [15:0] ea_q;
    logic        illegal_q;
    logic [15:0] sext9, sext11, sext6;

    assign sext9  = {{7{ir_q[8]}},  ir_q[8:0]};
    assign sext11 = {{5{ir_q[10]}}, ir_q[10:0]};
    assign sext6  = {{10{ir_q[5]}}, ir_q[5:0]};

    // Opcode classification; LDI/STI share the PC-relative form and add the fetch flag.
    always_comb begin
        mode_d = M_NONE;
        ind_d  = 1'b0;
        case (ir_q[15:12])
            4'b0000, 4'b0010, 4'b0011, 4'b1110: mode_d = M_PC9;
            4'b1010, 4'b1011: begin
`ifdef EA_INDIRECT_EN
                mode_d = M_PC9;
                ind_d  = 1'b1;
`else
                mode_d = M_NONE;
`endif
            end
            4'b0100:          mode_d = ir_q[11] ? M_PC11 : M_BASE0;
            4'b1100:          mode_d = M_BASE0;
            4'b0110, 4'b0111: mode_d = M_BASE6;
            default:          mode_d = M_NONE;
        endcase
    end

    always_comb begin
        sum_d     = 16'h0000;
        illegal_d = 1'b0;
        case (mode_q)
            M_PC9:   sum_d = pc_q + sext9;
            M_PC11:  sum_d = pc_q + sext11;
            M_BASE0: sum_d = BaseR;
            M_BASE6: sum_d = BaseR + sext6;
            default: illegal_d = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (Start) state_d = S_DECODE;
            S_DECODE: state_d = S_CALC;
`ifdef EA_INDIRECT_EN
            S_CALC:   state_d = ind_q ? S_IND : S_DONE;
            S_IND:    if (Mem_Rdy) state_d = S_DONE;
`else
            S_CALC:   state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef EA_INDIRECT_EN
    logic [15:0] sum_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            sum_q <= 16'h0000;
        else if (state == S_CALC)
            sum_q <= sum_d;
    end

    assign Mem_Req  = (state == S_IND);
    assign Mem_Addr = (state == S_IND) ? sum_q : 16'h0000;
`else
    logic unused_mem;
    assign unused_mem = ^{Mem_Rdy, Mem_Data};
    assign Mem_Req    = 1'b0;
    assign Mem_Addr   = 16'h0000;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            ir_q      <= 16'h0000;
            pc_q      <= 16'h0000;
            mode_q    <= M_NONE;
            ind_q     <= 1'b0;
            ea_q      <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        ir_q <= IR;
                        pc_q <= PC;
                    end
                end
                S_DECODE: begin
                    mode_q <= mode_d;
                    ind_q  <= ind_d;
                end
                S_CALC: begin
                    // Direct modes publish the result on entry to DONE so EA is valid with Done.
                    if (!ind_q) begin
                        ea_q      <= sum_d;
                        illegal_q <= illegal_d;
                    end
                end
`ifdef EA_INDIRECT_EN
                S_IND: begin
                    if (Mem_Rdy) begin
                        ea_q      <= Mem_Data;
                        illegal_q <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign BaseR_Sel = ir_q[8:6];
    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);
    assign EA        = ea_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_ea_sequencer.sv
// tb/tb_ea_sequencer.sv - randomized self-checking bench for ea_sequencer against an arithmetic reference model.
module tb_ea_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] IR, PC;
    logic [2:0]  BaseR_Sel;
    logic [15:0] BaseR;
    logic        Mem_Req;
    logic [15:0] Mem_Addr;
    logic        Mem_Rdy;
    logic [15:0] Mem_Data;
    logic        Busy, Done;
    logic [15:0] EA;
    logic        Illegal;

    logic [15:0] regs [8];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign BaseR = regs[BaseR_Sel];

    ea_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .PC(PC),
        .BaseR_Sel(BaseR_Sel), .BaseR(BaseR), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
        .Mem_Rdy(Mem_Rdy), .Mem_Data(Mem_Data), .Busy(Busy), .Done(Done),
        .EA(EA), .Illegal(Illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] base,
                                  input logic [15:0] memd, output logic [15:0] ea, output logic [15:0] ptr,
                                  output logic ill, output logic ind);
        int op, off, addr;
        op = int'(ir[15:12]);
        ill = 1'b0;
        ind = 1'b0;
        addr = 0;
        if (op == 0 || op == 2 || op == 3 || op == 14 || op == 10 || op == 11) begin
            off = int'(ir[8:0]);
            if (off >= 256) off -= 512;
            addr = int'(pc) + off;
            ind = (op == 10 || op == 11);
        end else if (op == 4 && ir[11]) begin
            off = int'(ir[10:0]);
            if (off >= 1024) off -= 2048;
            addr = int'(pc) + off;
        end else if (op == 4 || op == 12) begin
            addr = int'(base);
        end else if (op == 6 || op == 7) begin
            off = int'(ir[5:0]);
            if (off >= 32) off -= 64;
            addr = int'(base) + off;
        end else begin
            ill = 1'b1;
        end
        ptr = addr[15:0];
        ea  = addr[15:0];
`ifdef EA_INDIRECT_EN
        if (ind) ea = memd;
`else
        if (ind) begin
            ind = 1'b0;
            ill = 1'b1;
            ea  = 16'h0000;
            ptr = 16'h0000;
        end
`endif
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Mem_Rdy = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string tag, input logic [15:0] ir, input logic [15:0] pc,
                          input int waits, input bit hold, input logic [15:0] memd);
        logic [15:0] exp_ea, exp_ptr, base;
        logic exp_ill, exp_ind;
        int lat, reqn;
        bit got;
        base = regs[ir[8:6]];
        model(ir, pc, base, memd, exp_ea, exp_ptr, exp_ill, exp_ind);
        IR = ir;
        PC = pc;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        if (!hold) Start = 1'b0;
        IR = 16'($urandom);
        PC = 16'($urandom);
        got = 1'b0;
        reqn = 0;
        lat = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge Clk);
            if (n == 0) check({tag, ".basersel"}, 32'(BaseR_Sel), 32'(ir[8:6]));
            if (Done) begin
                got = 1'b1;
                lat = n + 1;
                Start = 1'b0;
                Mem_Rdy = 1'b0;
            end else begin
                check({tag, ".busy"}, 32'(Busy), 32'd1);
                if (Mem_Req) begin
                    reqn++;
                    check({tag, ".memaddr"}, 32'(Mem_Addr), 32'(exp_ptr));
                    Mem_Rdy = (reqn == waits + 1);
                    Mem_Data = Mem_Rdy ? memd : 16'($urandom);
                end else begin
                    Mem_Rdy = 1'($urandom_range(0, 1));
                    Mem_Data = 16'($urandom);
                end
                @(posedge Clk);
            end
        end
        if (!got) begin
            check({tag, ".timeout"}, 32'd0, 32'd1);
            do_reset();
            return;
        end
        check({tag, ".latency"}, 32'(lat), exp_ind ? 32'(4 + waits) : 32'd3);
        check({tag, ".reqcycles"}, 32'(reqn), exp_ind ? 32'(waits + 1) : 32'd0);
        check({tag, ".ea"}, 32'(EA), 32'(exp_ea));
        check({tag, ".illegal"}, 32'(Illegal), 32'(exp_ill));
        @(posedge Clk);
        @(negedge Clk);
        check({tag, ".idle_busy"}, 32'(Busy), 32'd0);
        check({tag, ".single_done"}, 32'(Done), 32'd0);
        check({tag, ".ea_held"}, 32'(EA), 32'(exp_ea));
        check({tag, ".ill_held"}, 32'(Illegal), 32'(exp_ill));
    endtask

    task automatic reset_check(input string tag);
        check({tag, ".busy"}, 32'(Busy), 32'd0);
        check({tag, ".done"}, 32'(Done), 32'd0);
        check({tag, ".memreq"}, 32'(Mem_Req), 32'd0);
        check({tag, ".memaddr"}, 32'(Mem_Addr), 32'd0);
        check({tag, ".ea"}, 32'(EA), 32'd0);
        check({tag, ".illegal"}, 32'(Illegal), 32'd0);
        check({tag, ".basersel"}, 32'(BaseR_Sel), 32'd0);
    endtask

    // Abort an operation mid-flight, then show that stray Mem_Rdy pulses produce nothing.
    task automatic reset_mid(input string tag, input logic [15:0] ir, input int at_n);
        IR = ir;
        PC = 16'h3000;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int n = 0; n <= at_n; n++) begin
            @(negedge Clk);
            Mem_Rdy = 1'b0;
            if (n < at_n) @(posedge Clk);
        end
`ifdef EA_INDIRECT_EN
        check({tag, ".req_before"}, 32'(Mem_Req), 32'd1);
`else
        check({tag, ".busy_before"}, 32'(Busy), 32'd1);
`endif
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        reset_check(tag);
        for (int k = 0; k < 4; k++) begin
            Mem_Rdy = 1'b1;
            Mem_Data = 16'($urandom);
            @(posedge Clk);
            @(negedge Clk);
            Mem_Rdy = 1'b0;
            check({tag, ".no_done"}, 32'(Done), 32'd0);
            check({tag, ".no_busy"}, 32'(Busy), 32'd0);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        IR = 16'h0000;
        PC = 16'h0000;
        Mem_Rdy = 1'b0;
        Mem_Data = 16'h0000;
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        reset_check("reset");

        run_op("ld", 16'h21FF, 16'h3001, 0, 1'b0, 16'h0000);
        regs[1] = 16'h4000;
        run_op("ldr", 16'h6060, 16'h1234, 0, 1'b0, 16'h0000);
        run_op("jsr", 16'h4BFF, 16'h3000, 0, 1'b0, 16'h0000);
        run_op("lea_wrap", 16'hE001, 16'hFFFF, 0, 1'b0, 16'h0000);
        run_op("ldi", 16'hA002, 16'h3000, 2, 1'b0, 16'h5000);
        run_op("sti_fast", 16'hB1FE, 16'h0001, 0, 1'b0, 16'hBEEF);
        run_op("illegal_hold", 16'h1000, 16'h3000, 0, 1'b1, 16'h0000);
        regs[5] = 16'h8001;
        run_op("jsrr", 16'h4140, 16'h3000, 0, 1'b1, 16'h0000);
        run_op("jmp", 16'hC140, 16'h3000, 0, 1'b0, 16'h0000);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            run_op("rand", 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 16'($urandom));
        end

`ifdef EA_INDIRECT_EN
        reset_mid("reset_ind", 16'hA002, 2);
`else
        reset_mid("reset_calc", 16'hA002, 1);
`endif
        run_op("after_reset", 16'h21FF, 16'h3001, 0, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
